// File: rtl/simd_op_stage.sv
// Purpose: queue 4x4-bit signed operand pairs in a circular FIFO, then add them lane-wise with saturation.
// Latency: 2 rising edges minimum (FIFO write, then result-register load); one result per cycle sustained.
// Backpressure: in_ready drops when the FIFO is full or flushing; the result register holds while out_ready=0.
module simd_op_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_a,
  input  logic [15:0]                in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_sum,
  output logic [3:0]                 out_sat,
  output logic [CNT_W-1:0]           sat_count,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);

  // FIFO storage: {a, b} per entry
  logic [31:0]      mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_sum_q, out_sum_d;
  logic [3:0]       out_sat_q, out_sat_d;
  logic [CNT_W-1:0] sat_count_q, sat_count_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [31:0]      head;
  logic [15:0]      lane_sum;
  logic [3:0]       lane_sat;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  // Gating with rst_n keeps the input closed for the whole reset interval.
  assign in_ready = rst_n && !full && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!out_valid_q || out_ready) && !flush;
  assign head     = mem_q[rd_ptr_q];

  // Per-lane 5-bit sum clamped to the 4-bit signed range; lanes never share a carry.
  always_comb begin
    lane_sum = '0;
    lane_sat = '0;
    for (int i = 0; i < 4; i++) begin
      logic [4:0] s;
      s = {head[16+4*i+3], head[16+4*i +: 4]} + {head[4*i+3], head[4*i +: 4]};
      if (s[4] != s[3]) begin
        // Sign bit of the 5-bit sum tells which rail was crossed.
        lane_sum[4*i +: 4] = s[4] ? 4'b1000 : 4'b0111;
        lane_sat[i]        = 1'b1;
      end else begin
        lane_sum[4*i +: 4] = s[3:0];
      end
    end
  end

  // Next-state for pointers, occupancy, result register and saturation counter.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;
    sat_count_d = sat_count_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + AW'(1);
        out_valid_d = 1'b1;
        out_sum_d   = lane_sum;
        out_sat_d   = lane_sat;
        if ((|lane_sat) && (sat_count_q != '1)) begin
          sat_count_d = sat_count_q + CNT_W'(1);
        end
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and result state, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= '0;
      sat_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a, in_b};
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;
  assign occupancy = count_q;

endmodule

// File: tb/tb_simd_op_stage.sv
// Purpose: directed bench for simd_op_stage with a result scoreboard.
// Latency: checks the 2-edge minimum path and sustained streaming.
// Backpressure: exercises a full FIFO, held results, flush and mid-stream reset.
module tb_simd_op_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [3:0]  out_sat;
  logic [7:0]  sat_count;
  logic [2:0]  occupancy;

  int n_assert = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_out    = 0;
  logic [19:0] exp_q[$];

  simd_op_stage #(.DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_sat   (out_sat),
    .sat_count (sat_count),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Reference: {sat[3:0], sum[15:0]} from plain integer lane arithmetic.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] sum;
    logic [3:0]  sat;
    sum = '0;
    sat = '0;
    for (int i = 0; i < 4; i++) begin
      int s;
      s = int'($signed(a[4*i +: 4])) + int'($signed(b[4*i +: 4]));
      if (s > 7) begin
        sum[4*i +: 4] = 4'h7;
        sat[i]        = 1'b1;
      end else if (s < -8) begin
        sum[4*i +: 4] = 4'h8;
        sat[i]        = 1'b1;
      end else begin
        sum[4*i +: 4] = s[3:0];
      end
    end
    return {sat, sum};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then advance past the rising edge.
  task automatic tick();
    logic [19:0] e;
    @(negedge clk);
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_a, in_b));
      n_acc++;
    end
    if (out_valid && out_ready) begin
      n_out++;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_sum", 32'(out_sum), 32'(e[15:0]));
        chk("sb_sat", 32'(out_sat), 32'(e[19:16]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Single isolated transaction with exact latency checks.
  task automatic push_one(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] xs, input logic [3:0] xf);
    in_a = a; in_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_edge1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_edge2_valid", 32'(out_valid), 32'd1);
    chk("direct_sum", 32'(out_sum), 32'(xs));
    chk("direct_sat", 32'(out_sat), 32'(xf));
    tick();
    chk("drop_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_sat_count", 32'(sat_count), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_occupancy", 32'(occupancy), 32'd0);
    @(posedge clk);
    #1;

    // Basic sums
    push_one(16'h1234, 16'h4321, 16'h5555, 4'h0);
    push_one(16'hF234, 16'h0001, 16'hF235, 4'h0);
    push_one(16'hAAAA, 16'h5555, 16'hFFFF, 4'h0);

    // Saturation in both directions
    push_one(16'hFFFF, 16'h0008, 16'hFFF8, 4'h1);
    chk("sat_count_1", 32'(sat_count), 32'd1);
    push_one(16'h7777, 16'h1111, 16'h7777, 4'hF);
    chk("sat_count_2", 32'(sat_count), 32'd2);

    // Backpressure: 6 offers, only 5 fit (4 in FIFO + 1 in result register)
    out_ready = 1'b0;
    n_acc = 0;
    for (int k = 1; k <= 6; k++) begin
      in_a = 16'h1111 * 16'(k); in_b = 16'h0000; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(n_acc), 32'd5);
    chk("bp_occupancy", 32'(occupancy), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    repeat (3) tick();
    chk("bp_hold_sum", 32'(out_sum), 32'h1111);
    chk("bp_hold_sat", 32'(out_sat), 32'h0);
    out_ready = 1'b1;
    n_out = 0;
    for (int c = 0; c < 20 && n_out < 5; c++) tick();
    chk("bp_drained_count", 32'(n_out), 32'd5);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("bp_occupancy_end", 32'(occupancy), 32'd0);

    // Flush with 3 queued, one held, and a same-cycle push offer
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_a = 16'h0101 * 16'(k); in_b = 16'h1010; in_valid = 1'b1;
      tick();
    end
    chk("fl_pre_occupancy", 32'(occupancy), 32'd3);
    chk("fl_pre_valid", 32'(out_valid), 32'd1);
    in_a = 16'h2222; in_b = 16'h2222; in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("fl_occupancy", 32'(occupancy), 32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_sat_count", 32'(sat_count), 32'd2);
    out_ready = 1'b1;
    n_out = 0;
    repeat (5) tick();
    chk("fl_no_output", 32'(n_out), 32'd0);

    // Counter saturation: 300 saturating results
    in_a = 16'h7777; in_b = 16'h1111; in_valid = 1'b1;
    n_out = 0;
    for (int c = 0; c < 400 && n_out < 300; c++) tick();
    chk("cnt_results", 32'(n_out), 32'd300);
    chk("cnt_saturated", 32'(sat_count), 32'd255);
    repeat (4) tick();
    chk("cnt_no_wrap", 32'(sat_count), 32'd255);

    // Reset mid-stream, asserted between edges
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_out_sum", 32'(out_sum), 32'd0);
    chk("mid_out_sat", 32'(out_sat), 32'd0);
    chk("mid_sat_count", 32'(sat_count), 32'd0);
    chk("mid_occupancy", 32'(occupancy), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
    n_out = 0;
    repeat (3) tick();
    chk("mid_no_partial", 32'(n_out), 32'd0);
    chk("mid_rel_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/simd_op_stage.md
SIMD_OP_STAGE -- requirements
Module: simd_op_stage

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, setting input FIFO entries (power of two, at least 2).
REQ-002 The block SHALL have parameter CNT_W, default 8, setting the saturation event counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous discard of all queued and held operations.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the operand pair is offered.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the FIFO can accept this cycle.
REQ-008 The block SHALL have ports in_a and in_b, input, 16 bits each: packed 4 x 4-bit signed lanes, lane0 = bits [3:0].
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result register holds a valid result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-011 The block SHALL have port out_sum, output, 16 bits: per-lane saturating signed sum.
REQ-012 The block SHALL have port out_sat, output, 4 bits: per-lane saturation flag for out_sum.
REQ-013 The block SHALL have port sat_count, output, CNT_W bits: count of results with any lane saturated.
REQ-014 The block SHALL have port occupancy, output, log2(DEPTH)+1 bits: current FIFO entry count.

Function
REQ-015 The block SHALL accept a pair when in_valid && in_ready; in_ready = !full && !flush; there is no bypass when full.
REQ-016 The FIFO SHALL be circular, with read/write pointers wrapping at DEPTH, and SHALL preserve order.
REQ-017 The block SHALL pop the FIFO head into the result register when FIFO is non-empty && (!out_valid || out_ready).
REQ-018 Push and pop in the same cycle SHALL leave occupancy unchanged; push-only SHALL add 1 and pop-only SHALL subtract 1.
REQ-019 Each lane SHALL compute a+b in 5 bits: above 7 gives 4'b0111, below -8 gives 4'b1000, otherwise the low 4 bits; the lane's out_sat bit SHALL be set exactly when clamped.
REQ-020 Lane arithmetic SHALL be independent, with no carry between lanes.
REQ-021 Minimum latency SHALL be 2 rising edges, from the accepting edge to the edge after which out_valid=1 with that result.
REQ-022 While out_valid && !out_ready, out_sum and out_sat SHALL hold stable.
REQ-023 When out_valid && out_ready and the FIFO is empty, out_valid SHALL drop to 0 on the next edge.
REQ-024 sat_count SHALL increment by 1 on each result-register load with |out_sat, saturate at all-ones, and never wrap.
REQ-025 flush=1 SHALL, on the next edge, empty the FIFO (occupancy=0), clear out_valid, and drop any push that cycle.
REQ-026 flush SHALL NOT alter sat_count.
REQ-027 Reads of empty FIFO state SHALL have no effect.

Reset
REQ-028 rst_n=0 SHALL immediately force out_valid=0, out_sum=0, out_sat=0, sat_count=0, occupancy=0 and pointers to 0.
REQ-029 During reset in_ready SHALL be 0; it SHALL be 1 on the first cycle after deassertion.
REQ-030 Reset asserted mid-operation SHALL discard all queued and held results with no partial output.

Verification
REQ-031 Reset check: assert rst_n=0 asynchronously between edges -> outputs zero at once; after release in_ready=1, occupancy=0.
REQ-032 Basic sums: push 1234+4321 -> out_sum=5555, out_sat=0, out_valid 2 edges later. Push F234+0001 -> F235. Push AAAA+5555 -> FFFF.
REQ-033 Saturation: FFFF+0008 -> FFF8, out_sat=0001, sat_count=1. Then 7777+1111 -> 7777, out_sat=1111, sat_count=2.
REQ-034 Backpressure: out_ready=0, offer 6 pairs -> 5 accepted, occupancy=4, in_ready=0. Then out_ready=1 -> all 5 results emerge in order with no loss or duplication.
REQ-035 Flush with 3 queued and out_valid=1, plus a same-cycle push -> next cycle occupancy=0, out_valid=0; sat_count unchanged; pushed pair never emerges.
REQ-036 Counter saturation: 300 saturating results -> sat_count=255 and stays there; then reset mid-stream -> everything is zero.
